// File: rtl/competition_player_if.sv
// Question-word stream between the entry stage (master) and the
// competition_player question bank (slave). Simple valid/ready handshake.
interface competition_player_if #(
  parameter int QW = 23
);
  logic          q_valid;
  logic [QW-1:0] q_data;
  logic          q_ready;

  modport master (output q_valid, output q_data, input q_ready);
  modport slave  (input q_valid, input q_data, output q_ready);
endinterface

// File: rtl/competition_player.sv
// competition_player: buffers question words from the entry stage, then
// replays them one at a time with a per-question countdown and a score kept
// from the external correct/incorrect verdict.
// Optional feature macro: COMP_PENALTY_EN -- when defined, wrong answers and
// expiries each take one point off the score (saturating at 0).
module competition_player #(
  parameter int DEPTH      = 16,
  parameter int QW         = 23,
  parameter int TICK_DIV   = 100000000,
  parameter int TIME_LIMIT = 10,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic                clk,
  input  logic                reset,
  competition_player_if.slave qin,
  input  logic                start,
  input  logic                abort,
  input  logic                ans_valid,
  input  logic                ans_correct,
  output logic [QW-1:0]       cur_q,
  output logic [IW-1:0]       cur_idx,
  output logic [CW-1:0]       q_count,
  output logic [3:0]          time_left,
  output logic [CW-1:0]       score,
  output logic                playing,
  output logic                done,
  output logic                timeout_pulse
);
  localparam int            TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [3:0]    T_RELOAD = 4'(TIME_LIMIT);
`ifdef COMP_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  typedef enum logic [1:0] {LOAD, ASK, NEXT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] q_count_reg, q_count_next;
  logic [IW-1:0] cur_idx_reg, cur_idx_next;
  logic [3:0]    time_left_reg, time_left_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [CW-1:0] score_reg, score_next;
  logic          alive_reg;

  logic [QW-1:0] mem [DEPTH];
  logic [QW-1:0] rd_data_reg;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [IW-1:0] rd_addr;
  logic          can_write;
  logic          tick_wrap;

  function automatic logic [CW-1:0] score_up(input logic [CW-1:0] s);
    return (s == FULL) ? s : s + CW'(1);
  endfunction

  // Only moves the score when the penalty build is selected.
  function automatic logic [CW-1:0] score_down(input logic [CW-1:0] s);
    return (!PENALTY || s == '0) ? s : s - CW'(1);
  endfunction

  // alive_reg holds q_ready low until the first edge after reset release.
  assign can_write   = alive_reg && (state_reg == LOAD) && (q_count_reg < FULL);
  assign qin.q_ready = can_write;
  assign tick_wrap   = (tick_reg == TICK_MAX);
  assign wr_addr     = q_count_reg[IW-1:0];
  assign rd_addr     = cur_idx_next;

  // Next-state and datapath decisions, priority abort > start > answer > expiry > write.
  always_comb begin
    state_next     = state_reg;
    q_count_next   = q_count_reg;
    cur_idx_next   = cur_idx_reg;
    time_left_next = time_left_reg;
    tick_next      = tick_reg;
    score_next     = score_reg;
    wr_en          = 1'b0;
    timeout_pulse  = 1'b0;
    if (abort) begin
      state_next     = LOAD;
      q_count_next   = '0;
      cur_idx_next   = '0;
      time_left_next = '0;
      tick_next      = '0;
      score_next     = '0;
    end else begin
      // A write is still taken alongside start so the word joins this replay.
      if (can_write && qin.q_valid) begin
        wr_en        = 1'b1;
        q_count_next = q_count_reg + CW'(1);
      end
      if (start && (state_reg != LOAD || q_count_next != '0)) begin
        state_next     = ASK;
        cur_idx_next   = '0;
        score_next     = '0;
        time_left_next = T_RELOAD;
        tick_next      = '0;
      end else begin
        unique case (state_reg)
          LOAD: ;
          ASK: begin
            if (ans_valid) begin
              score_next = ans_correct ? score_up(score_reg) : score_down(score_reg);
              state_next = NEXT;
            end else if (tick_wrap) begin
              tick_next      = '0;
              time_left_next = time_left_reg - 4'd1;
              if (time_left_reg == 4'd1) begin
                timeout_pulse = 1'b1;
                score_next    = score_down(score_reg);
                state_next    = NEXT;
              end
            end else begin
              tick_next = tick_reg + TW'(1);
            end
          end
          NEXT: begin
            if (({1'b0, cur_idx_reg} + CW'(1)) < q_count_reg) begin
              cur_idx_next   = cur_idx_reg + IW'(1);
              time_left_next = T_RELOAD;
              tick_next      = '0;
              state_next     = ASK;
            end else begin
              state_next = DONE;
            end
          end
          DONE: ;
        endcase
      end
    end
  end

  // Control and counter registers, cleared asynchronously by reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= LOAD;
      q_count_reg   <= '0;
      cur_idx_reg   <= '0;
      time_left_reg <= '0;
      tick_reg      <= '0;
      score_reg     <= '0;
      alive_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_count_reg   <= q_count_next;
      cur_idx_reg   <= cur_idx_next;
      time_left_reg <= time_left_next;
      tick_reg      <= tick_next;
      score_reg     <= score_next;
      alive_reg     <= 1'b1;
    end
  end

  // Question bank with registered read; a same-address write is forwarded
  // so a word written together with start is presented immediately.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= qin.q_data;
    end
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_reg <= qin.q_data;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign cur_q     = (state_reg == ASK) ? rd_data_reg : '0;
  assign cur_idx   = cur_idx_reg;
  assign q_count   = q_count_reg;
  assign time_left = time_left_reg;
  assign score     = score_reg;
  assign playing   = (state_reg == ASK) || (state_reg == NEXT);
  assign done      = (state_reg == DONE);
endmodule

// File: doc/competition_player.md
Name: competition_player

Overview:
- Downstream stage of the competition question-entry block.
- Buffers the 23-bit question words that the entry stage produces, then replays them one at a time to the answer/check stage.
- Runs a per-question countdown and keeps the score from an external correct/incorrect verdict.
- Question word format: [22:18] mode one-hot, [17:16] op/radix code, [15:8] operand a, [7:0] operand b.

Parameters:
- DEPTH, 16, question bank entries (power of 2); IW = clog2(DEPTH), CW = IW+1.
- QW, 23, question word width.
- TICK_DIV, 100000000, clk cycles per countdown tick (1 s at 100 MHz).
- TIME_LIMIT, 10, ticks allowed per question (1..15).

Ports:
- clk, in, 1, system clock.
- reset, in, 1: async, active-low. Low clears all state immediately; logic runs when high.
- q_valid, in, 1: question word offered by the entry stage.
- q_data, in, QW: question word.
- q_ready, out, 1: bank accepts a word this cycle.
- start, in, 1: single-cycle pulse; begins or restarts replay.
- abort, in, 1: single-cycle pulse; clears the bank and score.
- ans_valid, in, 1: single-cycle pulse; an answer was submitted for cur_q.
- ans_correct, in, 1: verdict for that answer, qualified by ans_valid.
- cur_q, out, QW: question being asked; 0 when not in ASK.
- cur_idx, out, IW: index of cur_q.
- q_count, out, CW: words stored.
- time_left, out, 4: remaining ticks for cur_q.
- score, out, CW: correct answers this replay.
- playing, out, 1: high in ASK/NEXT.
- done, out, 1: high in DONE.
- timeout_pulse, out, 1: one cycle when a question expires.

Behaviour:
- Reset values: all outputs 0; state LOAD; bank contents undefined; q_count 0. q_ready goes 1 on the first cycle after reset release.
- States: LOAD, ASK, NEXT, DONE.
- Priority each cycle: abort > start > ans_valid > timer expiry > q_valid write.
- abort (any state):
  - next state LOAD; q_count, score, cur_idx, time_left, tick counter all 0.
  - A write offered in the same cycle is dropped.
- LOAD:
  - q_ready = (q_count < DEPTH), combinational.
  - Write on q_valid & q_ready: mem[q_count] <= q_data; q_count +1.
  - Full (q_count == DEPTH): q_ready 0; offered words are ignored, no error flag.
  - start with post-write q_count > 0 → ASK. A write in the same cycle is accepted and included.
  - On entry to ASK: cur_idx 0, score 0, time_left TIME_LIMIT, tick counter 0.
  - start with q_count == 0: ignored, stay LOAD.
- ASK:
  - cur_q = mem[cur_idx]; q_ready 0.
  - Tick counter counts 0..TICK_DIV-1. On wrap, time_left -1.
  - ans_valid: score +1 if ans_correct (saturates at DEPTH, unreachable in practice) → NEXT.
  - Expiry (time_left == 1 at tick wrap): time_left becomes 0; timeout_pulse = 1 for that cycle; no score change → NEXT.
  - ans_valid on the expiry cycle: treated as an answer, no timeout_pulse.
  - start in ASK: restart replay from index 0, score 0, timer reloaded.
  - Input latency: cur_q valid the cycle after entering ASK. Answer → next cur_q takes exactly 2 cycles (ASK→NEXT→ASK).
- NEXT (1 cycle):
  - If cur_idx+1 < q_count: cur_idx +1, timer reloaded → ASK.
  - Else → DONE; cur_idx holds the last index.
  - ans_valid in NEXT is ignored.
- DONE:
  - done 1; score held; cur_q 0; q_ready 0.
  - start → ASK with the same bank, score 0, cur_idx 0.
  - abort → LOAD.
- Reset asserted mid-operation: state, counters and outputs go to reset values asynchronously, without waiting for a clk edge.

Optional Feature:
- Macro: COMP_PENALTY_EN.
- Defined: ans_valid with ans_correct = 0 decrements score, saturating at 0. Expiry also decrements, saturating at 0.
- Undefined: wrong answers and expiries leave score unchanged.

Test Plan (DEPTH=4, TICK_DIV=4, TIME_LIMIT=3):
- Reset, then 5 back-to-back q_valid with words 0x010102, 0x020304, 0x040506, 0x080708, 0x100000 → first four accepted; q_count=4; q_ready=0 on the 5th; mem[3]=0x080708.
- start, then answers correct, wrong, correct, correct, each 1 cycle after cur_q updates → cur_q sequence 0x010102..0x080708, cur_idx 0..3, score 3, done=1 two cycles after the last ans_valid.
- start, no answers → per question: time_left 3,2,1,0 at 4-cycle intervals; timeout_pulse on cycle 12 of each ASK; done after 4 expiries; score 0.
- ans_valid=1, ans_correct=1 on the exact expiry cycle → no timeout_pulse, score +1. start with q_count=0 → stays LOAD.
- abort during ASK at cur_idx=2 → next cycle LOAD, q_count 0, score 0, q_ready 1. Async reset low mid-ASK → all outputs 0 before the next clk edge.
- With COMP_PENALTY_EN: answers wrong, correct, wrong, wrong → score 0,1,0,0 (saturation at 0). Without the macro → score 1.
